cpu_trace_unit: RTL
===================

Name: cpu_trace_unit

Overview:
- Synthesizable on-chip retire-trace recorder for the pipelined CPU; the next generation of the simulation-only trace/stat monitor.
- Samples writeback (register) and memory-stage events plus halt every cycle, timestamps them and queues them in a parametrised multi-write FIFO.
- Drained by a debug/host port through a valid/ready handshake.
- Also keeps cycle and instruction counters, a drop counter and a cycle-limit watchdog.

Parameters:
- DW, 16, register/memory data width
- AW, 16, memory address width; also the event tag width (register index zero-extended to AW)
- RW, 4, register index width
- DEPTH, 16, FIFO entries; power of two, minimum 4
- CW, 32, width of the cycle, instruction and drop counters and of the timestamp
- MAX_CYCLES, 100000, watchdog limit

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- trace_en  in  1  1 = push events into the FIFO; counters run regardless
- wb_reg_write  in  1  register file written this cycle
- wb_reg  in  RW  destination register
- wb_data  in  DW  register write data
- mem_read  in  1  memory read this cycle
- mem_write  in  1  memory write this cycle
- mem_addr  in  AW  memory address
- mem_wdata  in  DW  store data
- mem_rdata  in  DW  load data
- halt  in  1  halt reached memory/writeback
- ev_valid  out  1  FIFO head valid
- ev_ready  in  1  consumer accepts head
- ev_type  out  2  0 REG, 1 LOAD, 2 STORE, 3 HALT
- ev_tag  out  AW  register index or address (0 for HALT)
- ev_data  out  DW  write/load/store data (0 for HALT)
- ev_cycle  out  CW  capture timestamp
- fifo_level  out  clog2(DEPTH+1)  occupancy
- cycle_count  out  CW  cycles spent in RUN
- inst_count  out  CW  retired-instruction count
- drop_count  out  CW  events lost to overflow
- overflow  out  1  sticky; some event was dropped
- proto_err  out  1  sticky; mem_read and mem_write asserted together
- halted  out  1  state == HALTED
- timeout  out  1  state == TIMEOUT

Behaviour:
- Reset (synchronous, active-low): every counter, pointer and level is 0; every sticky flag is 0; ev_valid=0; state=RUN. Reset mid-operation discards FIFO contents.
- States:
  - RUN to HALTED on halt=1.
  - RUN to TIMEOUT when cycle_count==MAX_CYCLES-1 at a posedge and halt=0.
  - HALTED and TIMEOUT are terminal until reset.
  - If halt=1 arrives in the limit cycle, the next state is HALTED.
- In RUN, each posedge: cycle_count+=1. inst_count+=1 if halt|wb_reg_write|mem_write. Stamp = cycle_count before the increment, so the first cycle after reset carries stamp 0.
- Event set per RUN cycle, pushed in fixed order REG, MEM, HALT (0 to 3 events):
  - REG if wb_reg_write.
  - STORE if mem_write.
  - LOAD if mem_read and not mem_write. If both are asserted, STORE only and proto_err is set.
  - HALT if halt.
- Pushes happen only when trace_en=1 and state==RUN. HALTED and TIMEOUT capture nothing but keep draining.
- Space check is all-or-nothing: if n events > DEPTH - fifo_level, where fifo_level is the pre-pop value, none are pushed, drop_count+=n and overflow is set. State transitions and counters are unaffected by drops.
- Latency: an event captured at posedge N is visible on ev_* after posedge N, provided the FIFO was empty. Outputs are registered and come from the FIFO head.
- Pop on ev_valid&ev_ready at the posedge. Push and pop in the same cycle are legal; fifo_level changes by pushes-pops.
- ev_* hold steady while ev_valid=1 and ev_ready=0.
- Pointers wrap modulo DEPTH; a multi-push writes wptr, wptr+1 and wptr+2 with wrap.
- Counters saturate at 2^CW-1; no wrap.

Decomposition:
- Package cpu_trace_pkg holds:
  - event-type constants EV_REG/EV_LOAD/EV_STORE/EV_HALT
  - state enum RUN/HALTED/TIMEOUT
  - packed entry struct {type, tag, data, cycle}
- Sub-module trace_fifo_mw: DEPTH-entry FIFO with 0..3 writes and 1 read per cycle, exposing level and free count. The top-level block holds the capture, counters and FSM.

Test Plan:
- Reset, then REG write r3=0x00AB in the first RUN cycle with ev_ready=1 -> the next cycle shows ev_valid=1, type 0, tag 0x0003, data 0x00AB, ev_cycle 0, inst_count 1.
- Same cycle: wb_reg_write r5=0x1111, mem_write addr 0x0040 data 0x2222, halt=1 -> three entries in order REG, STORE, HALT with equal stamps; halted=1 next cycle; inst_count +1 only; no further captures.
- ev_ready=0, DEPTH=16: push 15 REG events, then a cycle with REG+LOAD -> both dropped, drop_count=2, overflow=1, fifo_level stays 15.
- mem_read=mem_write=1, addr 0x0010 -> a single STORE entry is recorded and proto_err=1.
- MAX_CYCLES=20, no halt -> timeout=1 after 20 RUN cycles, cycle_count=20; later events are ignored while the queued FIFO still drains.
- Assert rst_n=0 for one cycle with 5 queued entries -> fifo_level=0, ev_valid=0, all counters 0, state RUN.

Source files
------------

// File: rtl/cpu_trace_pkg.sv
// Shared types for the retire-trace recorder: event codes, FSM states and the
// packed FIFO entry layout.
package cpu_trace_pkg;

  localparam int TRACE_DW = 16;
  localparam int TRACE_AW = 16;
  localparam int TRACE_CW = 32;

  localparam logic [1:0] EV_REG   = 2'd0;
  localparam logic [1:0] EV_LOAD  = 2'd1;
  localparam logic [1:0] EV_STORE = 2'd2;
  localparam logic [1:0] EV_HALT  = 2'd3;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    HALTED  = 2'd1,
    TIMEOUT = 2'd2
  } traceState_t;

  typedef struct packed {
    logic [1:0]          evType;
    logic [TRACE_AW-1:0] tag;
    logic [TRACE_DW-1:0] data;
    logic [TRACE_CW-1:0] cycle;
  } traceEntry_t;

endpackage

// File: rtl/cpu_trace_unit_fifo.sv
// Circular FIFO that accepts up to three writes and one read per clock.
// The caller guarantees wrCount never exceeds the reported free count.
module trace_fifo_mw #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [1:0]                   wrCount,
  input  logic [2:0][W-1:0]            wrData,
  input  logic                         rdEn,
  output logic [W-1:0]                 rdData,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic [$clog2(DEPTH+1)-1:0]   free
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic          doPop;

  assign doPop  = rdEn && (level != '0);
  assign rdData = mem[rptr];
  assign free   = LW'(DEPTH) - level;

  // Write slots land at consecutive addresses, wrapping naturally with the pointer width
  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (2'(i) < wrCount) mem[wptr + PW'(i)] <= wrData[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      wptr  <= wptr + PW'(wrCount);
      if (doPop) rptr <= rptr + PW'(1);
      level <= level + LW'(wrCount) - LW'(doPop);
    end
  end

endmodule

// File: rtl/cpu_trace_unit.sv
// Retire-trace recorder: captures writeback, memory and halt events into a
// timestamped queue and keeps cycle/instruction/drop counters plus a watchdog.
module cpu_trace_unit
  import cpu_trace_pkg::*;
#(
  parameter int DW         = TRACE_DW,
  parameter int AW         = TRACE_AW,
  parameter int RW         = 4,
  parameter int DEPTH      = 16,
  parameter int CW         = TRACE_CW,
  parameter int MAX_CYCLES = 100000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       trace_en,
  input  logic                       wb_reg_write,
  input  logic [RW-1:0]              wb_reg,
  input  logic [DW-1:0]              wb_data,
  input  logic                       mem_read,
  input  logic                       mem_write,
  input  logic [AW-1:0]              mem_addr,
  input  logic [DW-1:0]              mem_wdata,
  input  logic [DW-1:0]              mem_rdata,
  input  logic                       halt,
  output logic                       ev_valid,
  input  logic                       ev_ready,
  output logic [1:0]                 ev_type,
  output logic [AW-1:0]              ev_tag,
  output logic [DW-1:0]              ev_data,
  output logic [CW-1:0]              ev_cycle,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level,
  output logic [CW-1:0]              cycle_count,
  output logic [CW-1:0]              inst_count,
  output logic [CW-1:0]              drop_count,
  output logic                       overflow,
  output logic                       proto_err,
  output logic                       halted,
  output logic                       timeout
);

  localparam int            LW    = $clog2(DEPTH+1);
  localparam logic [CW-1:0] LIMIT = CW'(MAX_CYCLES - 1);

  traceState_t       state, stateNext;
  logic [CW-1:0]     cycleCount, instCount, dropCount;
  logic              overflowFlag, protoErrFlag;
  logic              running, capture, fits;
  logic [1:0]        nEvents, wrCount;
  traceEntry_t [2:0] slots;
  traceEntry_t       head;
  logic [LW-1:0]     level, free;

  function automatic logic [CW-1:0] satAdd(input logic [CW-1:0] v, input logic [1:0] n);
    logic [CW:0] sum;
    sum = {1'b0, v} + (CW+1)'(n);
    return sum[CW] ? '1 : sum[CW-1:0];
  endfunction

  assign running = (state == RUN);
  assign capture = running && trace_en;

  always_comb begin
    stateNext = state;
    case (state)
      RUN: begin
        if (halt)                     stateNext = HALTED;
        else if (cycleCount == LIMIT) stateNext = TIMEOUT;
      end
      default: stateNext = state;
    endcase
  end

  // Events are packed into consecutive slots in REG, MEM, HALT order
  always_comb begin
    slots   = '0;
    nEvents = 2'd0;
    if (wb_reg_write) begin
      slots[nEvents] = '{evType: EV_REG, tag: AW'(wb_reg), data: wb_data, cycle: cycleCount};
      nEvents = nEvents + 2'd1;
    end
    if (mem_write) begin
      slots[nEvents] = '{evType: EV_STORE, tag: mem_addr, data: mem_wdata, cycle: cycleCount};
      nEvents = nEvents + 2'd1;
    end else if (mem_read) begin
      slots[nEvents] = '{evType: EV_LOAD, tag: mem_addr, data: mem_rdata, cycle: cycleCount};
      nEvents = nEvents + 2'd1;
    end
    if (halt) begin
      slots[nEvents] = '{evType: EV_HALT, tag: '0, data: '0, cycle: cycleCount};
      nEvents = nEvents + 2'd1;
    end
  end

  assign fits    = LW'(nEvents) <= free;
  assign wrCount = (capture && fits) ? nEvents : 2'd0;

  trace_fifo_mw #(
    .W     ($bits(traceEntry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wrCount (wrCount),
    .wrData  (slots),
    .rdEn    (ev_valid && ev_ready),
    .rdData  (head),
    .level   (level),
    .free    (free)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= RUN;
      cycleCount   <= '0;
      instCount    <= '0;
      dropCount    <= '0;
      overflowFlag <= 1'b0;
      protoErrFlag <= 1'b0;
    end else begin
      state <= stateNext;
      if (running) begin
        cycleCount <= satAdd(cycleCount, 2'd1);
        if (halt || wb_reg_write || mem_write) instCount <= satAdd(instCount, 2'd1);
        if (mem_read && mem_write) protoErrFlag <= 1'b1;
      end
      // A burst that does not fit is discarded whole
      if (capture && !fits) begin
        dropCount    <= satAdd(dropCount, nEvents);
        overflowFlag <= 1'b1;
      end
    end
  end

  assign ev_valid    = (level != '0);
  assign ev_type     = head.evType;
  assign ev_tag      = head.tag;
  assign ev_data     = head.data;
  assign ev_cycle    = head.cycle;
  assign fifo_level  = level;
  assign cycle_count = cycleCount;
  assign inst_count  = instCount;
  assign drop_count  = dropCount;
  assign overflow    = overflowFlag;
  assign proto_err   = protoErrFlag;
  assign halted      = (state == HALTED);
  assign timeout     = (state == TIMEOUT);

endmodule
